// File: rtl/gmii_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : gmii_tx_framer
//  Purpose  : Turns a valid/ready/last byte stream of forwarded frame bytes
//             (destination MAC through payload) into a complete GMII transmit
//             frame: preamble, SFD, data, zero padding, CRC-32 FCS and IFG.
//             Source underrun or oversize aborts the frame with tx_er.
//  Revision : 1.0 - initial release
// ============================================================================
module gmii_tx_framer #(
    parameter int MIN_DATA   = 60,
    parameter int MAX_DATA   = 1514,
    parameter int IFG_CYCLES = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] iData,
    input  logic       iValid,
    input  logic       iLast,
    output logic       oReady,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       oBusy,
    output logic       oFrameDone,
    output logic       oUnderrun
);

    // State encoding
    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_PREAMBLE = 3'd1;
    localparam logic [2:0] c_SFD      = 3'd2;
    localparam logic [2:0] c_DATA     = 3'd3;
    localparam logic [2:0] c_PAD      = 3'd4;
    localparam logic [2:0] c_FCS      = 3'd5;
    localparam logic [2:0] c_IFG      = 3'd6;

    // With a zero gap the framer returns straight to IDLE after a frame.
    localparam logic [2:0] c_AFTER_FRAME = (IFG_CYCLES > 0) ? c_IFG : c_IDLE;

    localparam int                 c_IFG_W    = (IFG_CYCLES > 2) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [c_IFG_W-1:0] c_IFG_LAST = c_IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam logic [c_IFG_W-1:0] c_IFG_ONE  = c_IFG_W'(1);

    localparam logic [10:0] c_MIN_DATA  = 11'(MIN_DATA);
    localparam logic [10:0] c_MAX_DATA  = 11'(MAX_DATA);
    localparam logic [31:0] c_CRC_INIT  = 32'hFFFF_FFFF;
    localparam logic [31:0] c_CRC_POLY  = 32'hEDB8_8320;

    logic [2:0]         r_state;
    logic [7:0]         r_txd;
    logic               r_tx_en;
    logic               r_tx_er;
    logic               r_done;
    logic               r_underrun;
    logic [10:0]        r_count;
    logic [31:0]        r_crc;
    logic [2:0]         r_pre_cnt;
    logic [1:0]         r_fcs_idx;
    logic [c_IFG_W-1:0] r_ifg_cnt;

    logic [10:0]        w_cnt_inc;
    logic [31:0]        w_crc_data;
    logic [31:0]        w_crc_pad;
    logic [31:0]        w_fcs;
    logic [7:0]         w_fcs_byte;

    // Reflected CRC-32 advanced by one octet, LSB of the octet first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data_in);
        logic [31:0] v_crc;
        v_crc = crc_in ^ {24'h00_0000, data_in};
        for (int k = 0; k < 8; k++) begin
            v_crc = v_crc[0] ? ((v_crc >> 1) ^ c_CRC_POLY) : (v_crc >> 1);
        end
        return v_crc;
    endfunction

    assign w_cnt_inc  = r_count + 11'd1;
    assign w_crc_data = crc32_byte(r_crc, iData);
    assign w_crc_pad  = crc32_byte(r_crc, 8'h00);
    assign w_fcs      = ~r_crc;
    assign w_fcs_byte = w_fcs[{r_fcs_idx, 3'b000} +: 8];

    // Ready drops once MAX_DATA bytes are in, so an extra byte is never taken.
    assign oReady     = (r_state == c_DATA) && (r_count != c_MAX_DATA);
    assign oBusy      = (r_state != c_IDLE);
    assign gmii_txd   = r_txd;
    assign gmii_tx_en = r_tx_en;
    assign gmii_tx_er = r_tx_er;
    assign oFrameDone = r_done;
    assign oUnderrun  = r_underrun;

    // Framing FSM with registered GMII outputs and status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_txd      <= 8'h00;
            r_tx_en    <= 1'b0;
            r_tx_er    <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            r_count    <= 11'd0;
            r_crc      <= c_CRC_INIT;
            r_pre_cnt  <= 3'd0;
            r_fcs_idx  <= 2'd0;
            r_ifg_cnt  <= '0;
        end else begin
            r_txd      <= 8'h00;
            r_tx_en    <= 1'b0;
            r_tx_er    <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_count   <= 11'd0;
                    r_crc     <= c_CRC_INIT;
                    r_pre_cnt <= 3'd0;
                    if (iValid) begin
                        r_state <= c_PREAMBLE;
                    end
                end
                c_PREAMBLE: begin
                    r_txd     <= 8'h55;
                    r_tx_en   <= 1'b1;
                    r_pre_cnt <= r_pre_cnt + 3'd1;
                    if (r_pre_cnt == 3'd6) begin
                        r_state <= c_SFD;
                    end
                end
                c_SFD: begin
                    r_txd   <= 8'hD5;
                    r_tx_en <= 1'b1;
                    r_state <= c_DATA;
                end
                c_DATA: begin
                    if (!iValid || (r_count == c_MAX_DATA)) begin
                        // Underrun or oversize: one errored cycle, no FCS.
                        r_tx_en    <= 1'b1;
                        r_tx_er    <= 1'b1;
                        r_underrun <= 1'b1;
                        r_ifg_cnt  <= '0;
                        r_state    <= c_AFTER_FRAME;
                    end else begin
                        r_txd   <= iData;
                        r_tx_en <= 1'b1;
                        r_crc   <= w_crc_data;
                        r_count <= w_cnt_inc;
                        if (iLast) begin
                            r_fcs_idx <= 2'd0;
                            r_state   <= (w_cnt_inc < c_MIN_DATA) ? c_PAD : c_FCS;
                        end
                    end
                end
                c_PAD: begin
                    r_txd   <= 8'h00;
                    r_tx_en <= 1'b1;
                    r_crc   <= w_crc_pad;
                    r_count <= w_cnt_inc;
                    if (w_cnt_inc >= c_MIN_DATA) begin
                        r_fcs_idx <= 2'd0;
                        r_state   <= c_FCS;
                    end
                end
                c_FCS: begin
                    r_txd     <= w_fcs_byte;
                    r_tx_en   <= 1'b1;
                    r_fcs_idx <= r_fcs_idx + 2'd1;
                    if (r_fcs_idx == 2'd3) begin
                        r_done    <= 1'b1;
                        r_ifg_cnt <= '0;
                        r_state   <= c_AFTER_FRAME;
                    end
                end
                c_IFG: begin
                    r_count   <= 11'd0;
                    r_crc     <= c_CRC_INIT;
                    r_ifg_cnt <= r_ifg_cnt + c_IFG_ONE;
                    if (r_ifg_cnt == c_IFG_LAST) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gmii_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gmii_tx_framer
//  Purpose  : Directed self-checking bench for gmii_tx_framer. Three
//             instances cover default, no-padding and short-MAX_DATA setups.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gmii_tx_framer;

    logic       clk;
    logic       reset;
    logic [7:0] d_data;
    logic       d_valid;
    logic       d_last;
    logic [1:0] sel;

    logic [2:0] valid_w;
    logic [2:0] ready_w;
    logic [2:0] en_w;
    logic [2:0] er_w;
    logic [2:0] busy_w;
    logic [2:0] done_w;
    logic [2:0] ur_w;
    logic [7:0] txd_w [3];

    logic [7:0] obs_txd;
    logic       obs_en;
    logic       obs_er;
    logic       obs_ready;
    logic       obs_busy;
    logic       obs_done;
    logic       obs_ur;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] frame_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] h_txd[$];
    bit         h_en[$];
    bit         h_er[$];
    bit         h_done[$];
    bit         h_ur[$];
    bit         h_rdy[$];
    bit         cap_en = 1'b0;

    int n_en;
    int n_er;
    int n_done;
    int n_ur;
    int first_en;
    int first_er;
    int first_done;

    assign valid_w[0] = d_valid && (sel == 2'd0);
    assign valid_w[1] = d_valid && (sel == 2'd1);
    assign valid_w[2] = d_valid && (sel == 2'd2);

    gmii_tx_framer u_dut_def (
        .clk(clk), .reset(reset), .iData(d_data), .iValid(valid_w[0]), .iLast(d_last),
        .oReady(ready_w[0]), .gmii_txd(txd_w[0]), .gmii_tx_en(en_w[0]), .gmii_tx_er(er_w[0]),
        .oBusy(busy_w[0]), .oFrameDone(done_w[0]), .oUnderrun(ur_w[0])
    );

    gmii_tx_framer #(.MIN_DATA(0)) u_dut_nopad (
        .clk(clk), .reset(reset), .iData(d_data), .iValid(valid_w[1]), .iLast(d_last),
        .oReady(ready_w[1]), .gmii_txd(txd_w[1]), .gmii_tx_en(en_w[1]), .gmii_tx_er(er_w[1]),
        .oBusy(busy_w[1]), .oFrameDone(done_w[1]), .oUnderrun(ur_w[1])
    );

    gmii_tx_framer #(.MAX_DATA(100)) u_dut_max (
        .clk(clk), .reset(reset), .iData(d_data), .iValid(valid_w[2]), .iLast(d_last),
        .oReady(ready_w[2]), .gmii_txd(txd_w[2]), .gmii_tx_en(en_w[2]), .gmii_tx_er(er_w[2]),
        .oBusy(busy_w[2]), .oFrameDone(done_w[2]), .oUnderrun(ur_w[2])
    );

    // Route the selected instance to the observation signals.
    always_comb begin
        obs_txd   = txd_w[0];
        obs_en    = en_w[0];
        obs_er    = er_w[0];
        obs_ready = ready_w[0];
        obs_busy  = busy_w[0];
        obs_done  = done_w[0];
        obs_ur    = ur_w[0];
        case (sel)
            2'd1: begin
                obs_txd = txd_w[1]; obs_en = en_w[1]; obs_er = er_w[1]; obs_ready = ready_w[1];
                obs_busy = busy_w[1]; obs_done = done_w[1]; obs_ur = ur_w[1];
            end
            2'd2: begin
                obs_txd = txd_w[2]; obs_en = en_w[2]; obs_er = er_w[2]; obs_ready = ready_w[2];
                obs_busy = busy_w[2]; obs_done = done_w[2]; obs_ur = ur_w[2];
            end
            default: begin
            end
        endcase
    end

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Record one sample of the selected pins per cycle on the falling edge.
    always @(negedge clk) begin
        if (cap_en) begin
            h_txd.push_back(obs_txd);
            h_en.push_back(obs_en);
            h_er.push_back(obs_er);
            h_done.push_back(obs_done);
            h_ur.push_back(obs_ur);
            h_rdy.push_back(obs_ready);
        end
    end

    // Bit-serial reference CRC-32 (reflected, poly 0xEDB88320).
    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB8_8320;
        end
        return c;
    endfunction

    // Append the expected pin bytes of frame_q (padded to pad_to) to exp_q.
    task automatic make_expected(input int pad_to);
        logic [31:0] crc;
        logic [7:0]  b;
        crc = 32'hFFFF_FFFF;
        for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int k = 0; k < frame_q.size(); k++) begin
            b = frame_q[k];
            exp_q.push_back(b);
            crc = crc_step(crc, b);
        end
        for (int k = frame_q.size(); k < pad_to; k++) begin
            exp_q.push_back(8'h00);
            crc = crc_step(crc, 8'h00);
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) exp_q.push_back(crc[8*k +: 8]);
    endtask

    task automatic start_capture();
        @(posedge clk);
        #1;
        h_txd.delete(); h_en.delete(); h_er.delete();
        h_done.delete(); h_ur.delete(); h_rdy.delete();
        cap_en = 1'b1;
    endtask

    task automatic stop_capture();
        @(posedge clk);
        #1;
        cap_en = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer frame_q bytes until n are accepted or stop_at is reached.
    task automatic drive_frame(input int n, input int stop_at, input bit use_last);
        int i;
        int cyc;
        i   = 0;
        cyc = 0;
        while (i < n && i < stop_at) begin
            @(negedge clk);
            d_valid = 1'b1;
            d_data  = frame_q[i];
            d_last  = use_last && (i == n - 1);
            if (obs_ready) i++;
            cyc++;
            if (cyc > 3000) begin
                n_checks++;
                n_fail++;
                $display("FAIL drive_timeout: accepted %0d bytes, required %0d", i, n);
                break;
            end
        end
    endtask

    // Reduce the captured history to counts, first indices and tx bytes.
    task automatic summarize();
        tx_q.delete();
        n_en = 0; n_er = 0; n_done = 0; n_ur = 0;
        first_en = -1; first_er = -1; first_done = -1;
        for (int k = 0; k < h_en.size(); k++) begin
            if (h_en[k]) begin
                n_en++;
                tx_q.push_back(h_txd[k]);
                if (first_en < 0) first_en = k;
            end
            if (h_er[k]) begin
                n_er++;
                if (first_er < 0) first_er = k;
            end
            if (h_done[k]) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
            if (h_ur[k]) n_ur++;
        end
    endtask

    task automatic test_reset();
        sel = 2'd0; d_valid = 1'b0; d_last = 1'b0; d_data = 8'h00;
        reset = 1'b0;
        wait_cycles(3);
        n_checks++; if (obs_txd !== 8'h00) begin n_fail++; $display("FAIL reset_txd: got %02h, expected 00", obs_txd); end
        n_checks++; if (obs_en !== 1'b0) begin n_fail++; $display("FAIL reset_tx_en: got %b, expected 0", obs_en); end
        n_checks++; if (obs_er !== 1'b0) begin n_fail++; $display("FAIL reset_tx_er: got %b, expected 0", obs_er); end
        n_checks++; if (obs_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", obs_done); end
        n_checks++; if (obs_ur !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b, expected 0", obs_ur); end
        n_checks++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", obs_busy); end
        n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, expected 0", obs_ready); end
        reset = 1'b1;
        wait_cycles(3);
        n_checks++; if (obs_busy !== 1'b0 || obs_en !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: busy=%b tx_en=%b, expected 0 0", obs_busy, obs_en);
        end
    endtask

    task automatic test_no_pad();
        logic [7:0] exp_b [21];
        exp_b = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
                  8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                  8'h26, 8'h39, 8'hF4, 8'hCB};
        sel = 2'd1;
        frame_q.delete();
        for (int k = 0; k < 9; k++) frame_q.push_back(8'(8'h31 + k));
        start_capture();
        drive_frame(9, 9, 1'b1);
        @(negedge clk); d_valid = 1'b0; d_last = 1'b0;
        wait_cycles(30);
        stop_capture();
        summarize();
        n_checks++; if (n_en !== 21) begin n_fail++; $display("FAIL nopad_en_cycles: got %0d, expected 21", n_en); end
        n_checks++; if (first_en !== 2) begin n_fail++; $display("FAIL nopad_latency: first tx_en at sample %0d, expected 2", first_en); end
        for (int k = 0; k < 21 && k < tx_q.size(); k++) begin
            n_checks++;
            if (tx_q[k] !== exp_b[k]) begin n_fail++; $display("FAIL nopad_byte[%0d]: got %02h, expected %02h", k, tx_q[k], exp_b[k]); end
        end
        n_checks++; if (n_done !== 1 || first_done !== 22) begin
            n_fail++; $display("FAIL nopad_done: %0d pulses at sample %0d, expected 1 at 22", n_done, first_done);
        end
        n_checks++; if (n_er !== 0) begin n_fail++; $display("FAIL nopad_tx_er: got %0d cycles, expected 0", n_er); end
    endtask

    task automatic test_padding();
        logic [7:0] hdr [14];
        hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h06};
        sel = 2'd0;
        frame_q.delete();
        for (int k = 0; k < 14; k++) frame_q.push_back(hdr[k]);
        exp_q.delete();
        make_expected(60);
        start_capture();
        drive_frame(14, 14, 1'b1);
        @(negedge clk); d_valid = 1'b0; d_last = 1'b0;
        wait_cycles(80);
        stop_capture();
        summarize();
        n_checks++; if (n_en !== 72) begin n_fail++; $display("FAIL pad_en_cycles: got %0d, expected 72", n_en); end
        n_checks++; if (tx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL pad_len: got %0d bytes, expected %0d", tx_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < tx_q.size(); k++) begin
            n_checks++;
            if (tx_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL pad_byte[%0d]: got %02h, expected %02h", k, tx_q[k], exp_q[k]); end
        end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL pad_done: got %0d pulses, expected 1", n_done); end
    endtask

    task automatic test_back_to_back();
        int gap;
        int rdy_in_gap;
        int j;
        sel = 2'd0;
        exp_q.delete();
        frame_q.delete();
        for (int k = 0; k < 64; k++) frame_q.push_back(8'(k * 7 + 3));
        make_expected(60);
        start_capture();
        drive_frame(64, 64, 1'b1);
        frame_q.delete();
        for (int k = 0; k < 64; k++) frame_q.push_back(8'(8'hC0 ^ k));
        make_expected(60);
        drive_frame(64, 64, 1'b1);
        @(negedge clk); d_valid = 1'b0; d_last = 1'b0;
        wait_cycles(30);
        stop_capture();
        summarize();
        gap = 0; rdy_in_gap = 0; j = first_done + 1;
        while (first_done >= 0 && j < h_en.size() && !h_en[j]) begin
            gap++;
            if (h_rdy[j]) rdy_in_gap++;
            j++;
        end
        n_checks++; if (gap !== 13) begin n_fail++; $display("FAIL b2b_gap: got %0d idle cycles, expected 13", gap); end
        n_checks++; if (rdy_in_gap !== 0) begin n_fail++; $display("FAIL b2b_ready_in_gap: got %0d cycles, expected 0", rdy_in_gap); end
        n_checks++; if (j >= h_txd.size() || h_txd[j] !== 8'h55) begin
            n_fail++; $display("FAIL b2b_next_preamble: sample %0d, expected 55 after gap", j);
        end
        n_checks++; if (n_done !== 2) begin n_fail++; $display("FAIL b2b_done: got %0d pulses, expected 2", n_done); end
        n_checks++; if (n_en !== 152) begin n_fail++; $display("FAIL b2b_en_cycles: got %0d, expected 152", n_en); end
        for (int k = 0; k < exp_q.size() && k < tx_q.size(); k++) begin
            n_checks++;
            if (tx_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL b2b_byte[%0d]: got %02h, expected %02h", k, tx_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_underrun();
        int idle;
        sel = 2'd0;
        frame_q.delete();
        for (int k = 0; k < 30; k++) frame_q.push_back(8'(8'h80 + k));
        start_capture();
        drive_frame(30, 20, 1'b1);
        @(negedge clk); d_valid = 1'b0; d_last = 1'b0;
        wait_cycles(25);
        stop_capture();
        summarize();
        n_checks++; if (first_er !== 30) begin n_fail++; $display("FAIL ur_abort_pos: got sample %0d, expected 30", first_er); end
        if (first_er > 0 && first_er + 12 < h_en.size()) begin
            n_checks++; if (h_txd[first_er - 1] !== 8'h93) begin n_fail++; $display("FAIL ur_last_byte: got %02h, expected 93", h_txd[first_er - 1]); end
            n_checks++; if (h_en[first_er] !== 1'b1 || h_txd[first_er] !== 8'h00 || h_ur[first_er] !== 1'b1) begin
                n_fail++; $display("FAIL ur_abort_cycle: tx_en=%b txd=%02h underrun=%b, expected 1 00 1", h_en[first_er], h_txd[first_er], h_ur[first_er]);
            end
            idle = 0;
            for (int k = first_er + 1; k <= first_er + 12; k++) if (!h_en[k] && !h_er[k]) idle++;
            n_checks++; if (idle !== 12) begin n_fail++; $display("FAIL ur_ifg: got %0d idle cycles, expected 12", idle); end
        end else begin
            n_checks++; n_fail++; $display("FAIL ur_no_abort: abort sample %0d, expected 30", first_er);
        end
        n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL ur_fcs_sent: got %0d done pulses, expected 0", n_done); end
        n_checks++; if (n_ur !== 1 || n_er !== 1) begin n_fail++; $display("FAIL ur_pulses: underrun=%0d tx_er=%0d, expected 1 1", n_ur, n_er); end
        n_checks++; if (n_en !== 29) begin n_fail++; $display("FAIL ur_en_cycles: got %0d, expected 29", n_en); end
    endtask

    task automatic test_oversize();
        sel = 2'd2;
        frame_q.delete();
        for (int k = 0; k < 100; k++) frame_q.push_back(8'(k + 1));
        start_capture();
        drive_frame(100, 100, 1'b0);
        @(negedge clk);
        d_valid = 1'b1; d_data = 8'hEE; d_last = 1'b0;
        n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL ovs_ready_101: got %b, expected 0", obs_ready); end
        @(negedge clk); d_valid = 1'b0;
        wait_cycles(20);
        stop_capture();
        summarize();
        n_checks++; if (first_er !== 110) begin n_fail++; $display("FAIL ovs_abort_pos: got sample %0d, expected 110", first_er); end
        if (first_er > 0) begin
            n_checks++; if (h_ur[first_er] !== 1'b1 || h_en[first_er] !== 1'b1 || h_txd[first_er] !== 8'h00) begin
                n_fail++; $display("FAIL ovs_abort_cycle: underrun=%b tx_en=%b txd=%02h, expected 1 1 00", h_ur[first_er], h_en[first_er], h_txd[first_er]);
            end
            n_checks++; if (h_txd[first_er - 1] !== 8'h64) begin n_fail++; $display("FAIL ovs_last_byte: got %02h, expected 64", h_txd[first_er - 1]); end
        end
        n_checks++; if (n_en !== 109 || n_done !== 0) begin
            n_fail++; $display("FAIL ovs_frame: tx_en=%0d done=%0d, expected 109 0", n_en, n_done);
        end
    endtask

    task automatic test_reset_midframe();
        sel = 2'd0;
        frame_q.delete();
        for (int k = 0; k < 60; k++) frame_q.push_back(8'(k * 3 + 1));
        drive_frame(60, 3, 1'b1);
        @(negedge clk);
        n_checks++; if (obs_en !== 1'b1 || obs_txd !== 8'h07) begin
            n_fail++; $display("FAIL rst_third_byte: tx_en=%b txd=%02h, expected 1 07", obs_en, obs_txd);
        end
        reset = 1'b0;
        d_valid = 1'b0; d_last = 1'b0;
        #1;
        n_checks++; if (obs_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tx_en: got %b, expected 0", obs_en); end
        n_checks++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b, expected 0", obs_busy); end
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(2);
        frame_q.delete();
        for (int k = 0; k < 60; k++) frame_q.push_back(8'(8'h5A ^ (k * 5)));
        exp_q.delete();
        make_expected(60);
        start_capture();
        drive_frame(60, 60, 1'b1);
        @(negedge clk); d_valid = 1'b0; d_last = 1'b0;
        wait_cycles(25);
        stop_capture();
        summarize();
        n_checks++; if (n_en !== 72 || n_done !== 1 || n_er !== 0) begin
            n_fail++; $display("FAIL rst_new_frame: tx_en=%0d done=%0d tx_er=%0d, expected 72 1 0", n_en, n_done, n_er);
        end
        for (int k = 0; k < exp_q.size() && k < tx_q.size(); k++) begin
            n_checks++;
            if (tx_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rst_byte[%0d]: got %02h, expected %02h", k, tx_q[k], exp_q[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_no_pad();
        test_padding();
        test_back_to_back();
        test_underrun();
        test_oversize();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
